// File: rtl/fpu_pkg.sv
// fpu_pkg: shared FPU operation codes and arbiter state encoding
package fpu_pkg;
  typedef enum logic [3:0] {
    op_add, op_sub, op_mul, op_div, op_sqrt, op_abs, op_neg, op_cmp,
    op_i2f, op_f2i, op_k_pi, op_k_piby2
  } e_fpu_operation;
  localparam e_fpu_operation FPU_OP_LAST = op_k_piby2;
  typedef enum logic [1:0] {arb_idle_st, arb_issue_st, arb_wait_st, arb_ack_st} e_arb_state;
endpackage

// File: rtl/fpu_rr_pick.sv
// fpu_rr_pick: combinational round-robin selector starting after last_grant
module fpu_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int GW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [GW-1:0]      last_grant,
  output logic [GW-1:0]      grant,
  output logic               any_req
);
  logic [GW-1:0] idx;
  assign any_req = |req;
  always_comb begin
    grant = last_grant;
    idx = last_grant;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = GW'((int'(last_grant) + i) % NUM_REQ);
      if (req[idx]) grant = idx;
    end
  end
endmodule

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin sharing of one FPU core with watchdog and four-phase ack
module fpu_arbiter
  import fpu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int W = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*4-1:0] req_op,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic [NUM_REQ-1:0]   ack,
  output logic [W-1:0]         result,
  output logic                 err,
  output logic                 core_start,
  output logic [3:0]           core_op,
  output logic [W-1:0]         core_a,
  output logic [W-1:0]         core_b,
  output logic                 core_abort,
  input  logic                 core_done,
  input  logic [W-1:0]         core_result,
  output logic                 busy
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  e_arb_state state, state_d;
  logic [GW-1:0] grant, last_grant, pick;
  logic [TW-1:0] wdog;
  logic any_req, expire;
  logic [3:0] op_arr [NUM_REQ];
  logic [W-1:0] a_arr [NUM_REQ];
  logic [W-1:0] b_arr [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign op_arr[i] = req_op[i*4 +: 4];
    assign a_arr[i] = req_a[i*W +: W];
    assign b_arr[i] = req_b[i*W +: W];
  end
  fpu_rr_pick #(.NUM_REQ(NUM_REQ), .GW(GW)) u_pick (
    .req(req),
    .last_grant(last_grant),
    .grant(pick),
    .any_req(any_req)
  );
  assign expire = wdog == TW'(TIMEOUT - 1);
  always_comb begin
    state_d = state;
    core_start = 1'b0;
    core_abort = 1'b0;
    ack = '0;
    busy = state != arb_idle_st;
    case (state)
      arb_idle_st: state_d = any_req ? arb_issue_st : arb_idle_st;
      arb_issue_st: begin
        core_start = core_op <= FPU_OP_LAST;
        state_d = core_start ? arb_wait_st : arb_ack_st;
      end
      arb_wait_st: begin
        core_abort = expire && !core_done;
        state_d = (core_done || expire) ? arb_ack_st : arb_wait_st;
      end
      arb_ack_st: begin
        ack[grant] = 1'b1;
        state_d = req[grant] ? arb_ack_st : arb_idle_st;
      end
    endcase
  end
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= arb_idle_st;
    else state <= state_d;
  end
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      grant <= '0;
      last_grant <= GW'(NUM_REQ - 1);
      core_op <= '0;
      core_a <= '0;
      core_b <= '0;
      result <= '0;
      err <= 1'b0;
      wdog <= '0;
    end else begin
      case (state)
        arb_idle_st: if (any_req) begin
          grant <= pick;
          core_op <= op_arr[pick];
          core_a <= a_arr[pick];
          core_b <= b_arr[pick];
        end
        arb_issue_st: begin
          wdog <= '0;
          if (core_op > FPU_OP_LAST) begin
            result <= '0;
            err <= 1'b1;
          end
        end
        arb_wait_st: begin
          wdog <= wdog + TW'(1);
          if (core_done) begin
            result <= core_result;
            err <= 1'b0;
          end else if (expire) begin
            result <= '0;
            err <= 1'b1;
          end
        end
        arb_ack_st: if (!req[grant]) last_grant <= grant;
      endcase
    end
  end
endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Shares the single FPU arithmetic core between up to four requesters, e.g. the CPU bus interface and the microcode sequencer. Requesters post an operation code and two operands. The block picks one requester round-robin, issues a one-cycle start to the core, and waits for done under a watchdog. It then returns the result to the winner with a four-phase acknowledge. It sits between the requester-side bus logic and the arithmetic core's start/done interface.

## Interface
- NUM_REQ, 2, number of requesters, legal 2..4
- W, 32, operand/result width
- TIMEOUT, 1023, max cycles from core_start to core_done before abort; counter width $clog2(TIMEOUT+1)
- clk  in  1  clock, all logic on rising edge
- arst  in  1  asynchronous active-high reset
- req  in  NUM_REQ  per-requester request level; held until ack seen
- req_op  in  NUM_REQ*4  per-requester operation (e_fpu_operation); stable while req high
- req_a  in  NUM_REQ*W  per-requester operand A; stable while req high
- req_b  in  NUM_REQ*W  per-requester operand B; stable while req high
- ack  out  NUM_REQ  per-requester acknowledge level
- result  out  W  result of the acknowledged operation; valid while any ack high
- err  out  1  error flag for the acknowledged operation; valid while any ack high
- core_start  out  1  one-cycle start pulse to the core
- core_op  out  4  operation to the core; registered at grant
- core_a  out  W  operand A to the core; registered at grant
- core_b  out  W  operand B to the core; registered at grant
- core_abort  out  1  one-cycle pulse that forces the core back to idle
- core_done  in  1  one-cycle completion pulse from the core
- core_result  in  W  core result; valid in the core_done cycle
- busy  out  1  high in any state other than arb_idle_st

## Operation
- States: arb_idle_st, arb_issue_st, arb_wait_st, arb_ack_st.
- arb_idle_st:
  - If any req is high, latch grant via round-robin, starting at the index after last_grant.
  - Register that requester's op/a/b into core_op/core_a/core_b, then go to arb_issue_st.
- arb_issue_st:
  - If core_op > op_k_piby2 (4'hC..4'hF): no core_start; set result=0, err=1; go to arb_ack_st.
  - Otherwise assert core_start for this one cycle, clear the watchdog, go to arb_wait_st.
- arb_wait_st:
  - Watchdog increments every cycle.
  - On core_done: capture core_result into result, set err=0, go to arb_ack_st.
  - If the watchdog reaches TIMEOUT first: pulse core_abort, set result=0, err=1, go to arb_ack_st.
  - core_done in the same cycle as expiry counts as a completion: no abort, err=0.
- arb_ack_st:
  - ack[grant]=1.
  - When req[grant]=0, drop ack, update last_grant=grant, go to arb_idle_st.
- core_done outside arb_wait_st is ignored.
- req changes for non-granted requesters never disturb the operation in flight.
- A requester that raises req again right after ack drops competes normally; round-robin prevents starvation.

## Timing
- Reset values:
  - ack=0, result=0, err=0, core_start=0, core_abort=0, core_op=0, core_a=0, core_b=0, busy=0
  - state=arb_idle_st
  - last_grant=NUM_REQ-1, so requester 0 wins the first tie
- arst mid-operation returns every output to its reset value immediately. No abort pulse is generated; the core sees its own reset.
- Latency (valid op): req sampled high at edge 0 → core_start high cycle 1 → core_done cycle k → ack high cycle k+1. result and err are registered and stable while ack is high.
- Invalid op: ack high at cycle 2.
- Timeout: core_abort is high in cycle 1+TIMEOUT; ack follows in the next cycle.
- Minimum back-to-back spacing: one idle cycle after ack falls.

## Structure
- Add e_arb_state (arb_idle_st..arb_ack_st) to the shared FPU package.
- Add the constant FPU_OP_LAST = op_k_piby2 to the same package.
- The operation enum is reused from that package unchanged.
- Sub-module fpu_rr_pick: combinational round-robin selector.
  - Inputs: req vector, last_grant.
  - Outputs: grant index, any_req.
  - fpu_arbiter registers its output.

## Test plan
- Single request: req[0], op_add, a=3F800000, b=40000000; core model returns 40400000 after 5 cycles → core_start at cycle 1, ack[0] at cycle 7, result=40400000, err=0.
- Contention: req[0] and req[1] both high from reset → requester 0 served first. req[0] re-asserted immediately after its ack drops → requester 1 served next; grants alternate 0,1,0,1 over 4 operations.
- Invalid op: req_op=4'hE → core_start never asserted; ack at cycle 2, result=0, err=1.
- Timeout: TIMEOUT=8, core never answers → core_abort one cycle at cycle 9, ack with err=1.
- Timeout race: core_done in the expiry cycle → no core_abort, err=0, core result returned.
- Reset mid-operation: arst pulsed in arb_wait_st → all outputs 0 at once. Stray core_done after reset is ignored; the next req is served normally with requester 0 priority.
